// File: rtl/cam_frame_writer_pkg.sv
// cam_frame_writer_pkg: shared FSM encoding, default geometry and colour-bar table.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cam_frame_writer_pkg;

  // Writer FSM states: idle, armed waiting for start-of-frame, expecting byte 1 / byte 2 of a pixel
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_B1       = 2'd2,
    ST_B2       = 2'd3
  } cam_state_t;

  localparam int DEF_WIDTH  = 160;
  localparam int DEF_HEIGHT = 120;
  // First address past the stored image; kept black by the reader side, never written here
  localparam int IMG_SIZE   = DEF_WIDTH * DEF_HEIGHT;

  // RGB332 colour-bar constants, left to right
  localparam logic [7:0] BAR_WHITE   = 8'hFF;
  localparam logic [7:0] BAR_YELLOW  = 8'hFC;
  localparam logic [7:0] BAR_CYAN    = 8'h1F;
  localparam logic [7:0] BAR_GREEN   = 8'h1C;
  localparam logic [7:0] BAR_MAGENTA = 8'hE3;
  localparam logic [7:0] BAR_RED     = 8'hE0;
  localparam logic [7:0] BAR_BLUE    = 8'h03;
  localparam logic [7:0] BAR_BLACK   = 8'h00;

  function automatic logic [7:0] bar_colour(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_rgb565_to_332.sv
// cam_rgb565_to_332: holds camera byte 1, packs byte 1 + byte 2 into one RGB332 pixel.
// Latency: o_pix_dat updates 1 cycle after the byte-2 strobe and holds until the next pixel.
// Backpressure: none; the camera byte stream cannot be stalled.
// Ports: clk, rst_n (async, active-low); i_b1_vld / i_b2_vld byte strobes; i_px_data camera byte;
//        o_pix_dat registered RGB332 pixel.
module cam_rgb565_to_332 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_b1_vld,
  input  logic       i_b2_vld,
  input  logic [7:0] i_px_data,
  output logic [7:0] o_pix_dat
);

  // Only the byte-1 bits that end up in the pixel are kept
  logic [5:0] r_b1;
  logic [7:0] r_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b1  <= 6'd0;
      r_pix <= 8'd0;
    end else begin
      if (i_b1_vld) begin
        r_b1 <= {i_px_data[7:5], i_px_data[2:0]};
      end
      if (i_b2_vld) begin
        r_pix <= {r_b1, i_px_data[4:3]};
      end
    end
  end

  assign o_pix_dat = r_pix;

endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: OV7670 RGB565 byte stream -> RGB332 frame-buffer write port, one write per pixel.
// Latency: regwrite/addr_in/data_in valid 1 cycle after byte 2 of a pixel is sampled.
// Backpressure: none; out-of-window pixels and odd trailing bytes are silently dropped.
// Ports: clk (PCLK), rst_n (async, active-low), cap_en, vsync, href, px_data in;
//        addr_in, data_in, regwrite (buffer write port), frame_done pulse, busy level out.
// Build option: CAM_TEST_PATTERN_EN replaces pixel data with 8 vertical colour bars.
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int AW     = 15,
  parameter int DW     = 8,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          busy
);

  // Counters reach WIDTH / HEIGHT (saturation value), so one extra code is needed
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);

  cam_state_t    r_state;
  cam_state_t    w_next;
  logic          r_vsync_q;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [AW-1:0] r_base;      // row * WIDTH, kept as a running sum
  logic          r_line_any;  // at least one byte accepted on the current line
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic          r_done;
  logic          r_busy;

  logic          w_vs_fall;
  logic          w_vs_rise;
  logic          w_sof;
  logic          w_eof;
  logic          w_b1_vld;
  logic          w_b2_vld;
  logic          w_in_frame;
  logic          w_line_end;
  logic          w_in_range;
  logic [7:0]    w_pix_dat;

  assign w_vs_fall = r_vsync_q & ~vsync;
  assign w_vs_rise = ~r_vsync_q & vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sof    = 1'b0;
    w_eof    = 1'b0;
    w_b1_vld = 1'b0;
    w_b2_vld = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cap_en) begin
          w_next = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: begin
        // cap_en is only honoured at start-of-frame; dropping it while armed disarms
        if (!cap_en) begin
          w_next = ST_IDLE;
        end else if (w_vs_fall) begin
          w_next = ST_B1;
          w_sof  = 1'b1;
        end
      end
      ST_B1: begin
        if (w_vs_rise) begin
          w_eof  = 1'b1;
          w_next = cap_en ? ST_WAIT_SOF : ST_IDLE;
        end else if (href) begin
          w_b1_vld = 1'b1;
          w_next   = ST_B2;
        end
      end
      ST_B2: begin
        if (w_vs_rise) begin
          w_eof  = 1'b1;
          w_next = cap_en ? ST_WAIT_SOF : ST_IDLE;
        end else if (href) begin
          w_b2_vld = 1'b1;
          w_next   = ST_B1;
        end else begin
          // line ended on an odd byte: drop it and restart pairing
          w_next = ST_B1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_in_frame = (r_state == ST_B1) || (r_state == ST_B2);
  assign w_line_end = w_in_frame && !w_vs_rise && !href && r_line_any;
  assign w_in_range = (r_col < CW'(WIDTH)) && (r_row < RW'(HEIGHT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_q  <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_base     <= '0;
      r_line_any <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_done    <= w_eof;
      r_wr      <= w_b2_vld && w_in_range;

      if (w_sof) begin
        r_busy <= 1'b1;
      end else if (w_eof) begin
        r_busy <= 1'b0;
      end

      if (w_b2_vld && w_in_range) begin
        r_addr <= r_base + AW'(r_col);
      end

      if (w_sof) begin
        r_col      <= '0;
        r_row      <= '0;
        r_base     <= '0;
        r_line_any <= 1'b0;
      end else begin
        if (w_b1_vld) begin
          r_line_any <= 1'b1;
        end
        // col stops at WIDTH so extra pixels never spill into the next row
        if (w_b2_vld && (r_col < CW'(WIDTH))) begin
          r_col <= r_col + 1'b1;
        end
        if (w_line_end) begin
          r_line_any <= 1'b0;
          r_col      <= '0;
          if (r_row < RW'(HEIGHT)) begin
            r_row  <= r_row + 1'b1;
            r_base <= r_base + AW'(WIDTH);
          end
        end
      end
    end
  end

  cam_rgb565_to_332 u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_b1_vld  (w_b1_vld),
    .i_b2_vld  (w_b2_vld),
    .i_px_data (px_data),
    .o_pix_dat (w_pix_dat)
  );

`ifdef CAM_TEST_PATTERN_EN
  // Bar index = col*8/WIDTH; only meaningful while col < WIDTH, which is when it is used
  logic [2:0] w_bar_idx;
  logic [7:0] r_pat;

  assign w_bar_idx = 3'((32'(r_col) * 8) / WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= 8'd0;
    end else if (w_b2_vld) begin
      r_pat <= bar_colour(w_bar_idx);
    end
  end

  assign data_in = DW'(r_pat);
`else
  assign data_in = DW'(w_pix_dat);
`endif

  assign addr_in    = r_addr;
  assign regwrite   = r_wr;
  assign frame_done = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_cam_frame_writer.sv
`timescale 1ns/1ps
module tb_cam_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap_en;
  logic        vsync;
  logic        href;
  logic [7:0]  px_data;
  logic [14:0] addr_in;
  logic [7:0]  data_in;
  logic        regwrite;
  logic        frame_done;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  // write log filled by the monitor only
  int wa[$];
  int wd[$];
  int done_cnt = 0;
  int hi_cnt   = 0;

  // expected writes for the test in progress
  int ea[$];
  int ed[$];

  cam_frame_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_en     (cap_en),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (regwrite) begin
      wa.push_back(int'(addr_in));
      wd.push_back(int'(data_in));
      if (int'(addr_in) >= 19200) hi_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      href    = 1'b1;
      px_data = (i % 2 == 0) ? b1 : b2;
    end
    idle(2);
  endtask

  task automatic sof();
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(3);
  endtask

  task automatic eof();
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    idle(3);
  endtask

  task automatic verify_writes(input string tag, input int base);
    int errs;
    errs = 0;
    check({tag, "_count"}, wa.size() - base, ea.size());
    for (int i = 0; i < ea.size() && base + i < wa.size(); i++) begin
      if (wa[base+i] != ea[i] || wd[base+i] != ed[i]) errs++;
    end
    check({tag, "_errs"}, errs, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_regwrite"}, regwrite, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_addr"}, addr_in, 0);
    check({tag, "_data"}, data_in, 0);
  endtask

  initial begin
    int b;
    int d;
    int npix;
    rst_n = 1'b0; cap_en = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");

    rst_n  = 1'b1;
    cap_en = 1'b1;
    idle(2);
    // bytes before any start-of-frame are ignored
    send_line(4, 8'hF8, 8'h1F);
    check("no_sof_writes", wa.size(), 0);

    // single pixel F8,1F -> E3 at address 0
    b = wa.size(); d = done_cnt;
    sof();
    check("busy_in_frame", busy, 1);
    send_line(2, 8'hF8, 8'h1F);
    ea = {0}; ed = {8'hE3};
    verify_writes("single", b);
    eof();
    check("single_done", done_cnt - d, 1);
    check("single_busy_after", busy, 0);

    // reset mid-frame: outputs clear at once, no frame_done
    b = wa.size(); d = done_cnt;
    sof();
    @(negedge clk); href = 1'b1; px_data = 8'hF8;
    @(negedge clk); px_data = 8'h1F;
    @(posedge clk); #2;
    check("prereset_regwrite", regwrite, 1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk); href = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    send_line(6, 8'hF8, 8'h1F);
    idle(3);
    check("postreset_writes", wa.size() - b, 0);
    check("postreset_done", done_cnt - d, 0);

    // full 160x120 frame of FF bytes
    b = wa.size(); d = done_cnt;
    sof();
    for (int r = 0; r < 120; r++) send_line(320, 8'hFF, 8'hFF);
    eof();
    ea.delete(); ed.delete();
    for (int i = 0; i < 19200; i++) begin ea.push_back(i); ed.push_back(8'hFF); end
    verify_writes("full", b);
    check("full_last_addr", wa[wa.size()-1], 19199);
    check("full_done", done_cnt - d, 1);

    // oversized frame: 130 lines, 200-pixel lines at the top and bottom, 1-pixel lines between
    b = wa.size(); d = done_cnt;
    sof();
    ea.delete(); ed.delete();
    for (int r = 0; r < 130; r++) begin
      npix = (r < 4 || r >= 116) ? 200 : 1;
      send_line(2 * npix, 8'h5A, 8'h3C);
      if (r < 120) begin
        for (int c = 0; c < npix && c < 160; c++) begin
          ea.push_back(r * 160 + c);
          ed.push_back(8'h4B);
        end
      end
    end
    eof();
    verify_writes("oversize", b);
    check("oversize_line2_addr", wa[b+160], 160);
    check("oversize_done", done_cnt - d, 1);

    // odd byte count: 3-byte line gives one write, next line pairs from byte 1 again
    b = wa.size();
    sof();
    send_line(3, 8'hF8, 8'h1F);
    send_line(2, 8'h5A, 8'h3C);
    eof();
    ea = {0, 160}; ed = {8'hE3, 8'h4B};
    verify_writes("odd", b);

    // cap_en dropped mid-frame: frame finishes, then the writer stays idle
    b = wa.size(); d = done_cnt;
    sof();
    send_line(4, 8'hF8, 8'h1F);
    cap_en = 1'b0;
    send_line(4, 8'h5A, 8'h3C);
    eof();
    ea = {0, 1, 160, 161}; ed = {8'hE3, 8'hE3, 8'h4B, 8'h4B};
    verify_writes("capoff", b);
    check("capoff_done", done_cnt - d, 1);
    check("capoff_busy", busy, 0);
    b = wa.size(); d = done_cnt;
    sof();
    check("capoff_no_busy", busy, 0);
    send_line(4, 8'hF8, 8'h1F);
    eof();
    check("capoff_no_writes", wa.size() - b, 0);
    check("capoff_no_done", done_cnt - d, 0);

    check("reserved_addr_writes", hi_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
